// File: rtl/vram_write_packer.sv
// Packs 16-bit pixel writes into 32-bit word writes: two lanes of one word share a
// holding register that is written out when full, on conflict, on timeout or on flush.
module vram_write_packer #(
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_ni,
  input  logic        vram_sel_i,
  input  logic        vram_wr_i,
  input  logic [3:0]  vram_mask_i,
  input  logic [31:0] vram_addr_i,
  input  logic [15:0] vram_data_in_i,
  output logic        vram_ack_o,
  output logic        mem_sel_o,
  output logic        mem_wr_o,
  output logic [3:0]  mem_mask_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic        mem_ack_i,
  input  logic        flush_i,
  output logic        idle_o
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    WRITE   = 2'd2
  } state_t;

  localparam logic [7:0] TIMER_LAST = 8'(FLUSH_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [30:0] hold_addr, hold_addr_nxt;
  logic [31:0] hold_data, hold_data_nxt;
  logic [3:0]  hold_mask, hold_mask_nxt;
  logic [1:0]  hold_lanes, hold_lanes_nxt;
  logic [7:0]  timer, timer_nxt;
  logic        ack_nxt;
  logic        mem_sel_nxt, mem_wr_nxt;
  logic [3:0]  mem_mask_nxt;
  logic [31:0] mem_addr_nxt, mem_data_nxt;

  logic        accept;
  logic        read_acc;
  logic        write_req;
  logic        mergeable;
  logic [30:0] req_word;
  logic [31:0] req_data;
  logic [3:0]  req_mask;
  logic [1:0]  req_lanes;
  logic        unused_mask_bits;

  // Only the low two byte enables describe a pixel; the upper pair is don't-care.
  assign unused_mask_bits = ^vram_mask_i[3:2];

  assign accept    = vram_sel_i && !vram_ack_o;
  assign read_acc  = accept && !vram_wr_i;
  assign write_req = accept && vram_wr_i;
  assign req_word  = vram_addr_i[31:1];
  assign req_data  = vram_addr_i[0] ? {vram_data_in_i, 16'h0000} : {16'h0000, vram_data_in_i};
  assign req_mask  = vram_addr_i[0] ? {vram_mask_i[1:0], 2'b00} : {2'b00, vram_mask_i[1:0]};
  assign req_lanes = vram_addr_i[0] ? 2'b10 : 2'b01;
  assign mergeable = (req_word == hold_addr) && ((hold_lanes & req_lanes) == 2'b00);
  assign idle_o    = (state == EMPTY) && !vram_sel_i;

  // Next-state and next-output logic for the packing FSM.
  always_comb begin
    state_nxt      = state;
    hold_addr_nxt  = hold_addr;
    hold_data_nxt  = hold_data;
    hold_mask_nxt  = hold_mask;
    hold_lanes_nxt = hold_lanes;
    timer_nxt      = timer;
    ack_nxt        = 1'b0;
    mem_sel_nxt    = mem_sel_o;
    mem_wr_nxt     = mem_wr_o;
    mem_addr_nxt   = mem_addr_o;
    mem_data_nxt   = mem_data_o;
    mem_mask_nxt   = mem_mask_o;
    case (state)
      EMPTY: begin
        if (accept) begin
          ack_nxt = 1'b1;
          if (vram_wr_i) begin
            hold_addr_nxt  = req_word;
            hold_data_nxt  = req_data;
            hold_mask_nxt  = req_mask;
            hold_lanes_nxt = req_lanes;
            timer_nxt      = 8'd0;
            state_nxt      = PARTIAL;
          end else begin
            state_nxt = EMPTY;
          end
        end else begin
          state_nxt = EMPTY;
        end
      end
      PARTIAL: begin
        // Any accepted request, reads included, restarts the idle timer.
        if (read_acc) begin
          ack_nxt   = 1'b1;
          timer_nxt = 8'd0;
        end else begin
          timer_nxt = timer + 8'd1;
        end
        if (write_req && mergeable) begin
          ack_nxt        = 1'b1;
          hold_data_nxt  = hold_data | req_data;
          hold_mask_nxt  = hold_mask | req_mask;
          hold_lanes_nxt = hold_lanes | req_lanes;
          mem_sel_nxt    = 1'b1;
          mem_wr_nxt     = 1'b1;
          mem_addr_nxt   = {1'b0, hold_addr};
          mem_data_nxt   = hold_data | req_data;
          mem_mask_nxt   = hold_mask | req_mask;
          state_nxt      = WRITE;
        end else if (write_req || flush_i || (!read_acc && (timer == TIMER_LAST))) begin
          // A conflicting write is left pending; it is taken once the word is out.
          mem_sel_nxt  = 1'b1;
          mem_wr_nxt   = 1'b1;
          mem_addr_nxt = {1'b0, hold_addr};
          mem_data_nxt = hold_data;
          mem_mask_nxt = hold_mask;
          state_nxt    = WRITE;
        end else begin
          state_nxt = PARTIAL;
        end
      end
      WRITE: begin
        if (mem_ack_i) begin
          mem_sel_nxt    = 1'b0;
          mem_wr_nxt     = 1'b0;
          hold_addr_nxt  = 31'd0;
          hold_data_nxt  = 32'd0;
          hold_mask_nxt  = 4'd0;
          hold_lanes_nxt = 2'd0;
          timer_nxt      = 8'd0;
          state_nxt      = EMPTY;
        end else begin
          state_nxt = WRITE;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  // State, holding register and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      state      <= EMPTY;
      hold_addr  <= 31'd0;
      hold_data  <= 32'd0;
      hold_mask  <= 4'd0;
      hold_lanes <= 2'd0;
      timer      <= 8'd0;
      vram_ack_o <= 1'b0;
      mem_sel_o  <= 1'b0;
      mem_wr_o   <= 1'b0;
      mem_addr_o <= 32'd0;
      mem_data_o <= 32'd0;
      mem_mask_o <= 4'd0;
    end else begin
      state      <= state_nxt;
      hold_addr  <= hold_addr_nxt;
      hold_data  <= hold_data_nxt;
      hold_mask  <= hold_mask_nxt;
      hold_lanes <= hold_lanes_nxt;
      timer      <= timer_nxt;
      vram_ack_o <= ack_nxt;
      mem_sel_o  <= mem_sel_nxt;
      mem_wr_o   <= mem_wr_nxt;
      mem_addr_o <= mem_addr_nxt;
      mem_data_o <= mem_data_nxt;
      mem_mask_o <= mem_mask_nxt;
    end
  end

endmodule

// File: tb/tb_vram_write_packer.sv
// Randomized bench for vram_write_packer against a transaction-level packing model.
module tb_vram_write_packer;

  localparam int FT = 16;

  logic        clk = 1'b0;
  logic        reset_ni = 1'b0;
  logic        vram_sel_i = 1'b0;
  logic        vram_wr_i = 1'b0;
  logic [3:0]  vram_mask_i = 4'd0;
  logic [31:0] vram_addr_i = 32'd0;
  logic [15:0] vram_data_in_i = 16'd0;
  logic        vram_ack_o;
  logic        mem_sel_o;
  logic        mem_wr_o;
  logic [3:0]  mem_mask_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_ack_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        idle_o;

  vram_write_packer #(.FLUSH_TIMEOUT(FT)) dut (
    .clk(clk), .reset_ni(reset_ni),
    .vram_sel_i(vram_sel_i), .vram_wr_i(vram_wr_i), .vram_mask_i(vram_mask_i),
    .vram_addr_i(vram_addr_i), .vram_data_in_i(vram_data_in_i), .vram_ack_o(vram_ack_o),
    .mem_sel_o(mem_sel_o), .mem_wr_o(mem_wr_o), .mem_mask_o(mem_mask_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i),
    .flush_i(flush_i), .idle_o(idle_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_writes = 0;
  int cyc = 0;
  int min_delay = 0;
  int max_delay = 3;
  int resp_cnt = -1;
  bit resp_en = 1'b1;

  // Expected word writes: {addr[31:0], data[31:0], mask[3:0]}
  logic [67:0] exp_q[$];
  bit          pend_v = 1'b0;
  logic [31:0] pend_word = 32'd0;
  bit          pend_has[2];
  logic [15:0] pend_data[2];
  logic [1:0]  pend_en[2];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_flush();
    logic [31:0] d;
    logic [3:0]  m;
    if (pend_v) begin
      d = {pend_has[1] ? pend_data[1] : 16'h0000, pend_has[0] ? pend_data[0] : 16'h0000};
      m = {pend_has[1] ? pend_en[1] : 2'b00, pend_has[0] ? pend_en[0] : 2'b00};
      exp_q.push_back({pend_word, d, m});
      pend_v = 1'b0;
      pend_has[0] = 1'b0;
      pend_has[1] = 1'b0;
    end
  endtask

  task automatic model_write(input logic [31:0] a, input logic [15:0] d, input logic [3:0] m);
    logic [31:0] w;
    int l;
    w = {1'b0, a[31:1]};
    l = int'(a[0]);
    if (pend_v && (w != pend_word || pend_has[l])) model_flush();
    pend_has[l] = 1'b1;
    pend_data[l] = d;
    pend_en[l] = m[1:0];
    if (!pend_v) begin
      pend_v = 1'b1;
      pend_word = w;
    end else begin
      model_flush();
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One upstream request; returns the cycles to ack and the cycle stamp of the ack.
  task automatic issue(input bit wr, input logic [31:0] a, input logic [15:0] d,
                       input logic [3:0] m, output int lat, output int ack_cyc);
    bit ok;
    ok = 1'b0;
    lat = 0;
    ack_cyc = 0;
    if (wr) model_write(a, d, m);
    vram_sel_i = 1'b1;
    vram_wr_i = wr;
    vram_addr_i = a;
    vram_data_in_i = d;
    vram_mask_i = m;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (vram_ack_o) begin
        ok = 1'b1;
        ack_cyc = cyc;
        break;
      end
    end
    vram_sel_i = 1'b0;
    if (!ok) check_val("ack_timeout", 64'd0, 64'd1);
    tick(1);
    check_val("ack_single_pulse", {63'd0, vram_ack_o}, 64'd0);
  endtask

  task automatic do_flush();
    model_flush();
    flush_i = 1'b1;
    tick(1);
    flush_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (idle_o && !mem_sel_o && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check_val(tag, {63'd0, ok}, 64'd1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream slave: acks each held write after a random delay.
  initial forever begin
    @(posedge clk);
    #1;
    if (!resp_en) begin
      mem_ack_i = 1'b0;
      resp_cnt = -1;
    end else if (mem_ack_i) begin
      mem_ack_i = 1'b0;
    end else if (mem_sel_o) begin
      if (resp_cnt < 0) resp_cnt = $urandom_range(max_delay, min_delay);
      if (resp_cnt == 0) begin
        mem_ack_i = 1'b1;
        resp_cnt = -1;
      end else begin
        resp_cnt--;
      end
    end else begin
      resp_cnt = -1;
    end
  end

  // Monitor: word-write contents and stability while a write is held off.
  initial begin
    bit prev_held;
    logic [67:0] prev_out;
    logic [67:0] e;
    prev_held = 1'b0;
    prev_out = 68'd0;
    forever begin
      @(negedge clk);
      if (mem_sel_o && prev_held) begin
        check_val("held_stable", {mem_addr_o, mem_data_o, mem_mask_o}, prev_out);
        check_val("no_ack_in_write", {63'd0, vram_ack_o}, 64'd0);
      end
      prev_held = mem_sel_o && !mem_ack_i;
      prev_out = {mem_addr_o, mem_data_o, mem_mask_o};
      if (mem_sel_o && mem_ack_i) begin
        n_writes++;
        check_val("mem_wr", {63'd0, mem_wr_o}, 64'd1);
        if (exp_q.size() == 0) begin
          check_val("unexpected_write", {32'd0, mem_addr_o}, 64'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check_val("mem_addr", {32'd0, mem_addr_o}, {32'd0, e[67:36]});
          check_val("mem_data", {32'd0, mem_data_o}, {32'd0, e[35:4]});
          check_val("mem_mask", {60'd0, mem_mask_o}, {60'd0, e[3:0]});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ac, w0, g, op;
    logic [31:0] cur;
    pend_has[0] = 1'b0;
    pend_has[1] = 1'b0;
    cur = 32'd0;

    tick(3);
    check_val("rst_ack", {63'd0, vram_ack_o}, 64'd0);
    check_val("rst_mem_sel", {63'd0, mem_sel_o}, 64'd0);
    check_val("rst_mem_wr", {63'd0, mem_wr_o}, 64'd0);
    check_val("rst_mem_out", {mem_addr_o, mem_data_o}, 64'd0);
    check_val("rst_mem_mask", {60'd0, mem_mask_o}, 64'd0);
    check_val("rst_idle", {63'd0, idle_o}, 64'd1);
    reset_ni = 1'b1;
    tick(2);

    // Pair of lanes into one word
    w0 = n_writes;
    issue(1'b1, 32'h10, 16'h1111, 4'hF, lat, ac);
    check_val("empty_accept_latency", 64'(lat), 64'd1);
    issue(1'b1, 32'h11, 16'h2222, 4'hF, lat, ac);
    check_val("pair_merge_latency", 64'(lat), 64'd1);
    wait_idle("pair_drain");
    check_val("pair_write_count", 64'(n_writes - w0), 64'd1);

    // Idle timeout
    issue(1'b1, 32'h21, 16'hABCD, 4'hF, lat, ac);
    model_flush();
    for (int i = 0; i < 100 && !mem_sel_o; i++) tick(1);
    check_val("timeout_cycles", 64'(cyc - ac), 64'(FT));
    wait_idle("timeout_drain");

    // Conflicting word: second request waits for the write-out
    w0 = n_writes;
    issue(1'b1, 32'h4, 16'h4444, 4'hF, lat, ac);
    issue(1'b1, 32'h8, 16'h8888, 4'hF, lat, ac);
    check_val("conflict_written_first", 64'(n_writes - w0), 64'd1);
    check_val("conflict_delayed_ack", {63'd0, lat > 1}, 64'd1);
    do_flush();
    wait_idle("conflict_drain");

    // Flush with withheld downstream ack
    min_delay = 5;
    max_delay = 5;
    w0 = n_writes;
    issue(1'b1, 32'h7, 16'h7777, 4'hF, lat, ac);
    do_flush();
    wait_idle("backpressure_drain");
    check_val("backpressure_write_count", 64'(n_writes - w0), 64'd1);
    min_delay = 0;
    max_delay = 3;

    // Reset while a write is held
    resp_en = 1'b0;
    issue(1'b1, 32'h40, 16'h4040, 4'hF, lat, ac);
    do_flush();
    for (int i = 0; i < 20 && !mem_sel_o; i++) tick(1);
    check_val("pre_reset_sel", {63'd0, mem_sel_o}, 64'd1);
    reset_ni = 1'b0;
    tick(1);
    check_val("mid_reset_sel", {63'd0, mem_sel_o}, 64'd0);
    check_val("mid_reset_wr", {63'd0, mem_wr_o}, 64'd0);
    check_val("mid_reset_out", {mem_addr_o, mem_data_o}, 64'd0);
    check_val("mid_reset_mask", {60'd0, mem_mask_o}, 64'd0);
    check_val("mid_reset_idle", {63'd0, idle_o}, 64'd1);
    reset_ni = 1'b1;
    exp_q.delete();
    w0 = n_writes;
    resp_en = 1'b1;
    tick(40);
    check_val("no_write_after_reset", 64'(n_writes - w0), 64'd0);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      op = $urandom_range(99, 0);
      if (op < 10) begin
        issue(1'b0, $urandom(), 16'($urandom()), 4'($urandom()), lat, ac);
      end else if (op < 20) begin
        do_flush();
      end else begin
        g = $urandom_range(99, 0);
        if (g < 60) cur = cur + 32'd1;
        else if (g < 90) cur = 32'($urandom_range(63, 0));
        else cur = $urandom();
        issue(1'b1, cur, 16'($urandom()), 4'($urandom()), lat, ac);
      end
      if ($urandom_range(99, 0) < 15) begin
        model_flush();
        tick(FT + 4);
      end else begin
        tick($urandom_range(2, 0));
      end
    end
    do_flush();
    wait_idle("random_drain");

    // Full 128x128 frame
    max_delay = 0;
    w0 = n_writes;
    for (int p = 0; p < 128 * 128; p++) begin
      issue(1'b1, 32'(p), 16'($urandom()), 4'hF, lat, ac);
    end
    wait_idle("frame_drain");
    check_val("frame_write_count", 64'(n_writes - w0), 64'd8192);
    check_val("final_idle", {63'd0, idle_o}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
